fifo_stream_reader: RTL

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_stream_reader.sv | 96 +++++++++
 1 files changed

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pops an upstream FIFO with one-cycle read latency and re-times
// the data onto a valid/ready stream. Optional macro: FIFO_STREAM_READER_XFER_CNT_EN.
module fifo_stream_reader #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    input  logic              flush,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready
`ifdef FIFO_STREAM_READER_XFER_CNT_EN
    ,
    output logic [15:0]       xfer_count
`endif
);

    // Stream handshake: a beat transfers on a rising edge where m_valid && m_ready;
    // while m_valid && !m_ready, m_valid and m_data hold their values.
    logic [1:0]        occ_q, occ_d;
    logic              inflight_q;
    logic              valid_q;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic              pop;
    logic              cap;
    logic [1:0]        base;
    logic [2:0]        level;

    assign pop   = valid_q && m_ready;
    assign cap   = inflight_q && !flush;
    assign level = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign base  = occ_q - {1'b0, pop};

    // Only request a byte when a slot is guaranteed free by the time it lands.
    assign fifo_rd_en = rst_n && !fifo_empty && !flush && (level < 3'd2);

    assign m_valid = valid_q;
    assign m_data  = head_q;

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        if (flush) begin
            occ_d = 2'd0;
        end else begin
            if (pop) begin
                head_d = tail_q;
            end
            // A captured byte lands behind whatever survives this cycle's pop.
            if (cap) begin
                if (base == 2'd0) begin
                    head_d = fifo_data;
                end else begin
                    tail_d = fifo_data;
                end
            end
            occ_d = base + {1'b0, cap};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            valid_q    <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= fifo_rd_en;
            valid_q    <= (occ_d != 2'd0);
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

`ifdef FIFO_STREAM_READER_XFER_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'd0;
        end else if (pop) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign xfer_count = cnt_q;
`endif

endmodule
